ibex_wb_buffer: RTL
===================

// Module: ibex_wb_buffer
// PURPOSE
//  Writeback buffer directly downstream of the execute block. It captures each EX result
//  (result, rd, we) when EX signals valid, and queues it in a DEPTH-entry FIFO. It drains
//  the FIFO to the register-file write port, which may stall for LSU writeback arbitration.
//  It also provides youngest-entry operand forwarding to ID and a retired-instruction counter.
// PARAMETERS
//  DEPTH      2   number of buffered entries, >=1; pointers wrap DEPTH-1 -> 0
//  CNT_W      32  width of retire counter
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      synchronous reset, active-high
//  ex_valid_i     in   1      EX result valid (EX stage valid output)
//  ex_ready_o     out  1      buffer can accept this cycle
//  ex_result_i    in   32     EX result (ALU/multdiv mux output)
//  ex_rd_addr_i   in   5      destination register
//  ex_rd_we_i     in   1      instruction writes rd
//  flush_i        in   1      discard all buffered, unwritten entries
//  rf_we_o        out  1      RF write request (head entry valid)
//  rf_waddr_o     out  5      head entry rd
//  rf_wdata_o     out  32     head entry data
//  rf_ready_i     in   1      RF port grants write this cycle
//  fwd_rs1_addr_i in   5      ID operand A address
//  fwd_rs2_addr_i in   5      ID operand B address
//  fwd_rs1_hit_o  out  1      rs1 matches a buffered entry
//  fwd_rs2_hit_o  out  1      rs2 matches a buffered entry
//  fwd_rs1_data_o out  32     data of youngest matching entry, '0 when no hit
//  fwd_rs2_data_o out  32     as above for rs2
//  retire_cnt_o   out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Reset (rst_i high at edge): count=0, rd/wr ptr=0, retire_cnt=0. rf_we_o=0.
//    ex_ready_o=0 while rst_i is high and 1 in the first cycle after reset. fwd hits=0.
//  - Push: ex_valid_i & ex_ready_o. Entry is stored only if ex_rd_we_i & ex_rd_addr_i!=0.
//    Otherwise (non-writing/x0) the instruction is not stored and retire_cnt increments
//    on that edge.
//  - ex_ready_o = (count != DEPTH) & ~flush_i. It is registered-count based. When the
//    buffer is full and popping in the same cycle, ex_ready_o is still 0 (no pass-through).
//  - Latency: entry pushed at edge N is on rf_* in cycle N+1. There is no combinational
//    EX->RF bypass.
//  - rf_we_o = (count != 0) & ~flush_i. rf_waddr_o/rf_wdata_o come from the head entry.
//    They hold stable while rf_we_o=1 & rf_ready_i=0.
//  - Pop: rf_we_o & rf_ready_i. rd ptr advances and retire_cnt increments.
//  - Simultaneous push+pop: count is unchanged and both pointers advance.
//  - Push of a non-stored instruction together with a pop: retire_cnt += 2.
//  - flush_i wins over push and pop. Next edge: count=0 and rd ptr=wr ptr=0; retire_cnt
//    is unchanged. Nothing is written to the RF during the flush cycle.
//  - Forwarding: combinational search over valid entries (head..tail).
//    - The youngest match wins.
//    - Address 0 never hits.
//    - The incoming ex_* of the same cycle is not searched.
//    - Entries are searched regardless of rf_ready_i.
//    - During flush_i, hits=0.
//  - retire_cnt wraps modulo 2^CNT_W, with no saturation.
//  - Pointer wrap: index DEPTH-1 +1 -> 0. count is kept in a $clog2(DEPTH+1)-bit register.
//  - rst_i mid-stall: all entries are dropped, with no RF write and no retire increment.
//  - X on ex_* inputs is ignored when ex_valid_i=0. An assertion checks that count<=DEPTH.
// TESTING
//  1 Single op: push r5=0x1234 with rf_ready_i=1 -> rf_we_o=1, waddr=5, wdata=0x1234 in
//    the next cycle. retire_cnt=1 one cycle later, after which buffer count=0.
//  2 Fill/stall, DEPTH=2: rf_ready_i=0, push r1=0xA, r2=0xB -> ex_ready_o=0. Third push
//    held. Raise rf_ready_i -> writes r1 then r2 in order, and ex_ready_o returns to 1.
//  3 Forwarding: rf_ready_i=0, push r3=0x11 then r3=0x22, fwd_rs1=3, fwd_rs2=0
//    -> rs1 hit=1 with data 0x22; rs2 hit=0 with data 0.
//  4 Non-writing ops: push 3 ops with ex_rd_we_i=0 and one with rd=x0 -> rf_we_o stays 0
//    and retire_cnt=4.
//  5 Flush: two entries buffered and rf_ready_i=1 with flush_i=1 in the same cycle
//    -> no RF write and count=0 next cycle; retire_cnt is unchanged and ex_ready_o=1.
//  6 Wrap/reset: preload retire_cnt near 2^32-1 via 3 retires past max -> wraps to 2.
//    Assert rst_i with 1 entry stalled -> rf_we_o=0 and retire_cnt=0 next cycle.

Source files
------------

// File: rtl/ibex_wb_buffer_if.sv
// rtl/ibex_wb_buffer_if.sv - bundle of EX capture, RF write, forwarding and retire signals
// Purpose: groups every non-clock/reset signal of ibex_wb_buffer.
// Ports (slave = the buffer):
//   ex_valid/ex_ready/ex_result/ex_rd_addr/ex_rd_we : EX result handshake
//   flush                                         : drop all unwritten entries
//   rf_we/rf_waddr/rf_wdata/rf_ready              : register-file write port
//   fwd_rs*_addr/fwd_rs*_hit/fwd_rs*_data         : ID operand forwarding
//   retire_cnt                                    : retired instruction count
interface ibex_wb_buffer_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_result;
  logic [4:0]       ex_rd_addr;
  logic             ex_rd_we;
  logic             flush;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             rf_ready;
  logic [4:0]       fwd_rs1_addr;
  logic [4:0]       fwd_rs2_addr;
  logic             fwd_rs1_hit;
  logic             fwd_rs2_hit;
  logic [31:0]      fwd_rs1_data;
  logic [31:0]      fwd_rs2_data;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output ex_valid, ex_result, ex_rd_addr, ex_rd_we, flush, rf_ready,
           fwd_rs1_addr, fwd_rs2_addr,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, fwd_rs1_hit, fwd_rs2_hit,
           fwd_rs1_data, fwd_rs2_data, retire_cnt
  );

  modport slave (
    input  ex_valid, ex_result, ex_rd_addr, ex_rd_we, flush, rf_ready,
           fwd_rs1_addr, fwd_rs2_addr,
    output ex_ready, rf_we, rf_waddr, rf_wdata, fwd_rs1_hit, fwd_rs2_hit,
           fwd_rs1_data, fwd_rs2_data, retire_cnt
  );
endinterface

// File: rtl/ibex_wb_buffer.sv
// rtl/ibex_wb_buffer.sv - writeback FIFO between EX and the register file
// Purpose: queues EX results that write a non-zero rd, drains them to the RF
//   write port in order, forwards the youngest buffered match to ID and counts
//   retired instructions (stored ones on RF write, non-writing ones on capture).
// Ports:
//   clk_i : clock, all state on the rising edge
//   rst_i : synchronous reset, active-high
//   bus   : ibex_wb_buffer_if slave (EX capture, RF write, forwarding, retire count)
module ibex_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  ibex_wb_buffer_if.slave bus
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);
  localparam logic [PTR_W-1:0]    LAST_C  = PTR_W'(DEPTH - 1);

  logic [31:0]         data_q [DEPTH];
  logic [4:0]          addr_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_W-1:0]    retire_q;

  logic push, store, pop;

  // Readiness depends only on the registered count, so a full buffer never
  // accepts in the same cycle it drains. Both handshakes are held off in reset.
  assign bus.ex_ready = ~rst_i & (count_q != DEPTH_C) & ~bus.flush;
  assign bus.rf_we    = ~rst_i & (count_q != '0) & ~bus.flush;
  assign bus.rf_waddr = addr_q[rd_ptr_q];
  assign bus.rf_wdata = data_q[rd_ptr_q];
  assign bus.retire_cnt = retire_q;

  assign push  = bus.ex_valid & bus.ex_ready;
  assign store = push & bus.ex_rd_we & (bus.ex_rd_addr != 5'd0);
  assign pop   = bus.rf_we & bus.rf_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      retire_q <= '0;
    end else if (bus.flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (store) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q  <= count_q + CNT_BITS'(store) - CNT_BITS'(pop);
      // A dropped (non-writing) capture and an RF write can retire together.
      retire_q <= retire_q + CNT_W'(push & ~store) + CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (store) begin
      data_q[wr_ptr_q] <= bus.ex_result;
      addr_q[wr_ptr_q] <= bus.ex_rd_addr;
    end
  end

  // Walk entries oldest to youngest so later matches overwrite earlier ones.
  logic [PTR_W-1:0] idx;
  always_comb begin
    bus.fwd_rs1_hit  = 1'b0;
    bus.fwd_rs2_hit  = 1'b0;
    bus.fwd_rs1_data = '0;
    bus.fwd_rs2_data = '0;
    idx              = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = (int'(rd_ptr_q) + i >= DEPTH) ? PTR_W'(int'(rd_ptr_q) + i - DEPTH)
                                          : PTR_W'(int'(rd_ptr_q) + i);
      if (i < int'(count_q)) begin
        if (bus.fwd_rs1_addr != 5'd0 && addr_q[idx] == bus.fwd_rs1_addr) begin
          bus.fwd_rs1_hit  = 1'b1;
          bus.fwd_rs1_data = data_q[idx];
        end
        if (bus.fwd_rs2_addr != 5'd0 && addr_q[idx] == bus.fwd_rs2_addr) begin
          bus.fwd_rs2_hit  = 1'b1;
          bus.fwd_rs2_data = data_q[idx];
        end
      end
    end
    if (bus.flush) begin
      bus.fwd_rs1_hit  = 1'b0;
      bus.fwd_rs2_hit  = 1'b0;
      bus.fwd_rs1_data = '0;
      bus.fwd_rs2_data = '0;
    end
  end

  count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DEPTH_C);

endmodule
